// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg.sv
// Opcode, function-code and ALU operation encodings.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    JR   = 6'h08,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    SUBU = 6'h23,
    AND  = 6'h24,
    OR   = 6'h25,
    XOR  = 6'h26,
    NOR  = 6'h27,
    SLT  = 6'h2a,
    SLTU = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// data_path_muxs_pkg.sv
// Control FSM states, wait-limit default and datapath mux selects.
package data_path_muxs_pkg;

  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALTED
  } state_t;

  typedef enum logic [1:0] {
    SEL_LOAD_NXT_INSTR,
    SEL_LOAD_IMM16,
    SEL_LOAD_JMP_ADDR,
    SEL_LOAD_REG
  } pc_src_t;

  typedef enum logic [1:0] {
    SEL_SRC_REG,
    SEL_SRC_IMM,
    SEL_SRC_SHAMT
  } alu_src_t;

  typedef enum logic [1:0] {
    SEL_ALU_RES,
    SEL_DLOAD,
    SEL_NPC,
    SEL_LUI
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    SEL_RD,
    SEL_RT,
    SEL_R31
  } reg_dest_t;

  typedef enum logic {
    EXT_ZERO,
    EXT_SIGN
  } extend_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder.sv
// Combinational IR field decode into ALU op and datapath mux selects.
module instr_decoder
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_fn,
  output aluop_t      o_alu_op,
  output alu_src_t    o_alu_src,
  output mem_to_reg_t o_mem_to_reg,
  output reg_dest_t   o_reg_dest,
  output extend_t     o_extend
);

  opcode_t w_op;
  funct_t  w_fn;

  assign w_op = opcode_t'(i_op);
  assign w_fn = funct_t'(i_fn);

  // per-opcode selects; unlisted opcodes keep the add/reg defaults
  always_comb begin
    o_alu_op     = ALU_ADD;
    o_alu_src    = SEL_SRC_REG;
    o_mem_to_reg = SEL_ALU_RES;
    o_reg_dest   = SEL_RT;
    o_extend     = EXT_SIGN;
    unique case (1'b1)
      (w_op == RTYPE): begin
        o_reg_dest = SEL_RD;
        unique case (1'b1)
          (w_fn == SLL): begin
            o_alu_op  = ALU_SLL;
            o_alu_src = SEL_SRC_SHAMT;
          end
          (w_fn == SRL): begin
            o_alu_op  = ALU_SRL;
            o_alu_src = SEL_SRC_SHAMT;
          end
          (w_fn == SUB) || (w_fn == SUBU):
            o_alu_op = ALU_SUB;
          (w_fn == AND):  o_alu_op = ALU_AND;
          (w_fn == OR):   o_alu_op = ALU_OR;
          (w_fn == XOR):  o_alu_op = ALU_XOR;
          (w_fn == NOR):  o_alu_op = ALU_NOR;
          (w_fn == SLT):  o_alu_op = ALU_SLT;
          (w_fn == SLTU): o_alu_op = ALU_SLTU;
          default: ;
        endcase
      end
      (w_op == ADDIU): o_alu_src = SEL_SRC_IMM;
      (w_op == SLTI): begin
        o_alu_op  = ALU_SLT;
        o_alu_src = SEL_SRC_IMM;
      end
      (w_op == SLTIU): begin
        o_alu_op  = ALU_SLTU;
        o_alu_src = SEL_SRC_IMM;
      end
      (w_op == ANDI): begin
        o_alu_op  = ALU_AND;
        o_alu_src = SEL_SRC_IMM;
        o_extend  = EXT_ZERO;
      end
      (w_op == ORI): begin
        o_alu_op  = ALU_OR;
        o_alu_src = SEL_SRC_IMM;
        o_extend  = EXT_ZERO;
      end
      (w_op == XORI): begin
        o_alu_op  = ALU_XOR;
        o_alu_src = SEL_SRC_IMM;
        o_extend  = EXT_ZERO;
      end
      (w_op == LUI): begin
        o_alu_src    = SEL_SRC_IMM;
        o_mem_to_reg = SEL_LUI;
        o_extend     = EXT_ZERO;
      end
      (w_op == LW): begin
        o_alu_src    = SEL_SRC_IMM;
        o_mem_to_reg = SEL_DLOAD;
      end
      (w_op == SW): o_alu_src = SEL_SRC_IMM;
      (w_op == BEQ) || (w_op == BNE):
        o_alu_op = ALU_SUB;
      (w_op == JAL): begin
        o_mem_to_reg = SEL_NPC;
        o_reg_dest   = SEL_R31;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit.sv
// Multicycle control FSM with IR, memory wait timeout and retire counter.
module multicycle_control_unit
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int WAIT_W   = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      instruction,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             equal,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RegWr,
  output aluop_t           alu_op,
  output alu_src_t         ALUSrc,
  output pc_src_t          PCSrc,
  output mem_to_reg_t      mem_to_reg,
  output reg_dest_t        reg_dest,
  output extend_t          extend,
  output logic             halt,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [WAIT_W-1:0] LP_WAIT_LAST =
    WAIT_W'(WAIT_MAX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_ir;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_err;
  opcode_t           w_op;
  funct_t            w_fn;
  logic              w_is_jr;
  logic              w_waiting;
  logic              w_wait_last;
  logic              w_err;
  logic              w_unused_ir;

  // only opcode and funct steer the FSM; the rest feeds the datapath
  assign w_op        = opcode_t'(r_ir[31:26]);
  assign w_fn        = funct_t'(r_ir[5:0]);
  assign w_unused_ir = ^r_ir[25:6];
  assign w_is_jr     = (w_op == RTYPE) && (w_fn == JR);
  assign w_wait_last = (r_wait == LP_WAIT_LAST);

  assign w_waiting =
    ((r_state == FETCH) && !ihit) ||
    ((r_state == MEMORY) && !dhit);

  assign halt        = (r_state == HALTED);
  assign bus_err     = r_bus_err;
  assign instr_count = r_cnt;

  instr_decoder u_dec (
    .i_op         (r_ir[31:26]),
    .i_fn         (r_ir[5:0]),
    .o_alu_op     (alu_op),
    .o_alu_src    (ALUSrc),
    .o_mem_to_reg (mem_to_reg),
    .o_reg_dest   (reg_dest),
    .o_extend     (extend)
  );

  // next state, strobes and PC source; all strobes forced low in reset
  always_comb begin
    w_next = r_state;
    iREN   = 1'b0;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    IRWr   = 1'b0;
    PCWr   = 1'b0;
    RegWr  = 1'b0;
    PCSrc  = SEL_LOAD_NXT_INSTR;
    w_err  = 1'b0;
    unique case (r_state)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          IRWr   = 1'b1;
          w_next = DECODE;
        end else if (w_wait_last) begin
          w_err  = 1'b1;
          w_next = HALTED;
        end
      end
      DECODE: begin
        w_next = (w_op == HALT) ? HALTED : EXECUTE;
      end
      EXECUTE: begin
        w_next = WRITEBACK;
        unique case (1'b1)
          (w_op == BEQ): begin
            PCWr   = 1'b1;
            w_next = FETCH;
            if (equal) PCSrc = SEL_LOAD_IMM16;
          end
          (w_op == BNE): begin
            PCWr   = 1'b1;
            w_next = FETCH;
            if (!equal) PCSrc = SEL_LOAD_IMM16;
          end
          (w_op == J): begin
            PCWr   = 1'b1;
            PCSrc  = SEL_LOAD_JMP_ADDR;
            w_next = FETCH;
          end
          w_is_jr: begin
            PCWr   = 1'b1;
            PCSrc  = SEL_LOAD_REG;
            w_next = FETCH;
          end
          (w_op == LW) || (w_op == SW):
            w_next = MEMORY;
          default: ;
        endcase
      end
      MEMORY: begin
        dREN = (w_op == LW);
        dWEN = (w_op == SW);
        if (dhit) begin
          if (w_op == SW) begin
            PCWr   = 1'b1;
            w_next = FETCH;
          end else begin
            w_next = WRITEBACK;
          end
        end else if (w_wait_last) begin
          w_err  = 1'b1;
          w_next = HALTED;
        end
      end
      WRITEBACK: begin
        RegWr  = 1'b1;
        PCWr   = 1'b1;
        w_next = FETCH;
        if (w_op == JAL) PCSrc = SEL_LOAD_JMP_ADDR;
      end
      HALTED: ;
      default: w_next = FETCH;
    endcase
    if (!nRST) begin
      iREN  = 1'b0;
      dREN  = 1'b0;
      dWEN  = 1'b0;
      IRWr  = 1'b0;
      PCWr  = 1'b0;
      RegWr = 1'b0;
      w_err = 1'b0;
    end
  end

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // instruction register, loaded only on IRWr
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     r_ir <= '0;
    else if (IRWr) r_ir <= instruction;
  end

  // wait counter: counts miss cycles, zero whenever not waiting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          r_wait <= '0;
    else if (w_waiting) r_wait <= r_wait + 1'b1;
    else                r_wait <= '0;
  end

  // saturating retired-instruction counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_cnt <= '0;
    else if (PCWr && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  // sticky bus error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      r_bus_err <= 1'b0;
    else if (w_err) r_bus_err <= 1'b1;
  end

endmodule
